// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the draw scheduler slice.
//   sched_state_t : scheduler FSM states
//   draw_cmd_t    : one draw-engine command {item, erase, pos}
//   ITEM_*        : item encodings, POS_MAX : highest slot position
//   DEF_*         : default per-sprite durations and counter width
package draw_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sched_state_t;

  typedef struct packed {
    logic       item;
    logic       erase;
    logic [2:0] pos;
  } draw_cmd_t;

  localparam logic        ITEM_PRESS = 1'b1;
  localparam logic        ITEM_GARB  = 1'b0;
  localparam logic [2:0]  POS_MAX    = 3'd5;

  localparam int unsigned DEF_PRESS_CYCLES = 2402;
  localparam int unsigned DEF_GARB_CYCLES  = 402;
  localparam int unsigned DEF_CNT_W        = 12;

endpackage

// File: rtl/draw_scheduler_slot.sv
// draw_req_slot: 1-deep pending command latch for one requester.
//   CLOCK_50, reset_n : clock, synchronous active-low reset
//   valid, item, erase, pos : one-cycle command pulse from the requester
//   grant : scheduler is taking the held command this cycle
//   pend  : a command is held and not yet served
//   cmd   : the held command
//   ovf   : one-cycle pulse, an unserved command was overwritten
module draw_req_slot
  import draw_scheduler_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       valid,
  input  logic       item,
  input  logic       erase,
  input  logic [2:0] pos,
  input  logic       grant,
  output logic       pend,
  output draw_cmd_t  cmd,
  output logic       ovf
);

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      pend <= 1'b0;
      cmd  <= '0;
      ovf  <= 1'b0;
    end else begin
      // Overwrite only counts as lost when the old command is not being taken now.
      ovf <= valid & pend & ~grant;
      if (valid) begin
        cmd  <= '{item: item, erase: erase, pos: pos};
        pend <= 1'b1;
      end else if (grant) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin sharing of the draw engine between the press
// sprite FSM (req0) and the garbage sprite FSM (req1).
//   CLOCK_50, reset_n          : clock, synchronous active-low reset
//   req{0,1}_valid/item/erase/pos : one-cycle command pulses
//   drw_item/erase/pos         : held command to the draw engine
//   drw_start                  : one-cycle engine start pulse
//   busy                       : operation in progress (ISSUE/WAIT/DONE)
//   grant_id                   : requester currently or last served
//   done0, done1               : one-cycle completion pulses
//   ovf0, ovf1                 : one-cycle pending-overwrite pulses
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int unsigned PRESS_CYCLES = DEF_PRESS_CYCLES,
  parameter int unsigned GARB_CYCLES  = DEF_GARB_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic       req0_item,
  input  logic       req0_erase,
  input  logic [2:0] req0_pos,
  input  logic       req1_valid,
  input  logic       req1_item,
  input  logic       req1_erase,
  input  logic [2:0] req1_pos,
  output logic       drw_item,
  output logic       drw_erase,
  output logic [2:0] drw_pos,
  output logic       drw_start,
  output logic       busy,
  output logic       grant_id,
  output logic       done0,
  output logic       done1,
  output logic       ovf0,
  output logic       ovf1
);

  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GARB_LOAD  = CNT_W'(GARB_CYCLES - 1);

  sched_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last_grant, last_n;
  logic             gid_n;
  draw_cmd_t        drw_cmd, cmd_n;
  logic             start_n, busy_n, done0_n, done1_n;

  logic             pend0, pend1, grant0, grant1, win;
  draw_cmd_t        cmd0, cmd1, sel;

  draw_req_slot u_slot0 (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .valid    (req0_valid),
    .item     (req0_item),
    .erase    (req0_erase),
    .pos      (req0_pos),
    .grant    (grant0),
    .pend     (pend0),
    .cmd      (cmd0),
    .ovf      (ovf0)
  );

  draw_req_slot u_slot1 (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .valid    (req1_valid),
    .item     (req1_item),
    .erase    (req1_erase),
    .pos      (req1_pos),
    .grant    (grant1),
    .pend     (pend1),
    .cmd      (cmd1),
    .ovf      (ovf1)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last_grant;
    gid_n   = grant_id;
    cmd_n   = drw_cmd;
    start_n = 1'b0;
    done0_n = 1'b0;
    done1_n = 1'b0;
    grant0  = 1'b0;
    grant1  = 1'b0;
    win     = 1'b0;
    sel     = cmd0;
    unique case (state)
      ST_IDLE: begin
        if (pend0 | pend1) begin
          win     = (pend0 & pend1) ? ~last_grant : pend1;
          grant0  = ~win;
          grant1  = win;
          sel     = win ? cmd1 : cmd0;
          cmd_n   = sel;
          gid_n   = win;
          cnt_n   = (sel.item == ITEM_PRESS) ? PRESS_LOAD : GARB_LOAD;
          start_n = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      // The ISSUE cycle already counts toward the duration, so the counter
      // steps here too; done then lands exactly dur cycles after drw_start.
      ST_ISSUE: begin
        cnt_n   = cnt - 1'b1;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_n = ST_DONE;
          done0_n = ~grant_id;
          done1_n = grant_id;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        last_n  = grant_id;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      drw_cmd    <= '0;
      drw_start  <= 1'b0;
      busy       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_n;
      grant_id   <= gid_n;
      drw_cmd    <= cmd_n;
      drw_start  <= start_n;
      busy       <= busy_n;
      done0      <= done0_n;
      done1      <= done1_n;
    end
  end

  assign drw_item  = drw_cmd.item;
  assign drw_erase = drw_cmd.erase;
  assign drw_pos   = drw_cmd.pos;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with short sprite durations
// (press = 6 cycles, garbage = 3 cycles).
module tb_draw_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic       req0_valid, req0_item, req0_erase;
  logic [2:0] req0_pos;
  logic       req1_valid, req1_item, req1_erase;
  logic [2:0] req1_pos;
  logic       drw_item, drw_erase, drw_start, busy, grant_id;
  logic [2:0] drw_pos;
  logic       done0, done1, ovf0, ovf1;

  draw_scheduler #(
    .PRESS_CYCLES (6),
    .GARB_CYCLES  (3),
    .CNT_W        (12)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_item  (req0_item),
    .req0_erase (req0_erase),
    .req0_pos   (req0_pos),
    .req1_valid (req1_valid),
    .req1_item  (req1_item),
    .req1_erase (req1_erase),
    .req1_pos   (req1_pos),
    .drw_item   (drw_item),
    .drw_erase  (drw_erase),
    .drw_pos    (drw_pos),
    .drw_start  (drw_start),
    .busy       (busy),
    .grant_id   (grant_id),
    .done0      (done0),
    .done1      (done1),
    .ovf0       (ovf0),
    .ovf1       (ovf1)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Event log, sampled mid-cycle.
  int start_cyc [0:63];
  int start_pos [0:63];
  int start_item[0:63];
  int start_ers [0:63];
  int start_gid [0:63];
  int done0_cyc [0:63];
  int done1_cyc [0:63];
  int n_start = 0, n_done0 = 0, n_done1 = 0, n_ovf0 = 0, n_ovf1 = 0;
  int ovf1_cyc = -1;

  always @(negedge CLOCK_50) begin
    if (drw_start && n_start < 64) begin
      start_cyc[n_start]  = cyc;
      start_pos[n_start]  = int'(drw_pos);
      start_item[n_start] = int'(drw_item);
      start_ers[n_start]  = int'(drw_erase);
      start_gid[n_start]  = int'(grant_id);
      n_start++;
    end
    if (done0 && n_done0 < 64) begin
      done0_cyc[n_done0] = cyc;
      n_done0++;
    end
    if (done1 && n_done1 < 64) begin
      done1_cyc[n_done1] = cyc;
      n_done1++;
    end
    if (ovf0) n_ovf0++;
    if (ovf1) begin
      n_ovf1++;
      ovf1_cyc = cyc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic nc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Drive a one-cycle command pulse; returns at the next negedge.
  task automatic post(input int id, input logic item, input logic erase, input logic [2:0] pos);
    if (id == 0) begin
      req0_valid = 1'b1; req0_item = item; req0_erase = erase; req0_pos = pos;
    end else begin
      req1_valid = 1'b1; req1_item = item; req1_erase = erase; req1_pos = pos;
    end
    @(negedge CLOCK_50);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    nc(2);
    reset_n = 1'b1;
    nc(1);
  endtask

  int t, bs, bd0, bd1, bo0, bo1;
  bit found;

  initial begin
    reset_n    = 1'b0;
    req0_valid = 1'b0; req0_item = 1'b0; req0_erase = 1'b0; req0_pos = '0;
    req1_valid = 1'b0; req1_item = 1'b0; req1_erase = 1'b0; req1_pos = '0;
    nc(3);

    // Reset state
    check_eq("rst_busy",  int'(busy), 0);
    check_eq("rst_start", int'(drw_start), 0);
    check_eq("rst_pos",   int'(drw_pos), 0);
    check_eq("rst_item",  int'(drw_item), 0);
    check_eq("rst_gid",   int'(grant_id), 0);
    check_eq("rst_done",  int'({done0, done1}), 0);
    check_eq("rst_ovf",   int'({ovf0, ovf1}), 0);
    reset_n = 1'b1;
    nc(2);

    // 1: single press-sprite draw, cycle-accurate
    t = cyc;
    post(0, 1'b1, 1'b0, 3'd3);
    check_eq("t1_busy_t1",  int'(busy), 0);
    check_eq("t1_start_t1", int'(drw_start), 0);
    nc(1);
    check_eq("t1_start_t2", int'(drw_start), 1);
    check_eq("t1_busy_t2",  int'(busy), 1);
    check_eq("t1_pos",      int'(drw_pos), 3);
    check_eq("t1_item",     int'(drw_item), 1);
    check_eq("t1_erase",    int'(drw_erase), 0);
    check_eq("t1_gid",      int'(grant_id), 0);
    nc(5);
    check_eq("t1_cyc_t7",   cyc - t, 7);
    check_eq("t1_done_t7",  int'(done0), 0);
    check_eq("t1_busy_t7",  int'(busy), 1);
    check_eq("t1_start_t7", int'(drw_start), 0);
    nc(1);
    check_eq("t1_done_t8",  int'(done0), 1);
    check_eq("t1_busy_t8",  int'(busy), 1);
    nc(1);
    check_eq("t1_busy_t9",  int'(busy), 0);
    check_eq("t1_done_t9",  int'(done0), 0);
    check_eq("t1_pos_hold", int'(drw_pos), 3);
    check_eq("t1_item_hold", int'(drw_item), 1);

    // 2: simultaneous requests after reset, req0 first
    do_reset();
    bs = n_start; bd0 = n_done0; bd1 = n_done1;
    t = cyc;
    req1_valid = 1'b1; req1_item = 1'b0; req1_erase = 1'b1; req1_pos = 3'd2;
    post(0, 1'b1, 1'b0, 3'd4);
    nc(20);
    check_eq("t2_nstart", n_start - bs, 2);
    check_eq("t2_s0_cyc", start_cyc[bs] - t, 2);
    check_eq("t2_s0_gid", start_gid[bs], 0);
    check_eq("t2_s0_pos", start_pos[bs], 4);
    check_eq("t2_d0_cyc", done0_cyc[bd0] - t, 8);
    check_eq("t2_s1_cyc", start_cyc[bs+1] - t, 10);
    check_eq("t2_s1_gid", start_gid[bs+1], 1);
    check_eq("t2_s1_pos", start_pos[bs+1], 2);
    check_eq("t2_s1_item", start_item[bs+1], 0);
    check_eq("t2_s1_ers", start_ers[bs+1], 1);
    check_eq("t2_ndone1", n_done1 - bd1, 1);
    check_eq("t2_d1_cyc", done1_cyc[bd1] - t, 13);

    // 3: req1 overwritten while busy, latest command wins
    bs = n_start; bd0 = n_done0; bd1 = n_done1; bo0 = n_ovf0; bo1 = n_ovf1;
    t = cyc;
    post(0, 1'b1, 1'b0, 3'd5);
    nc(2);
    post(1, 1'b0, 1'b0, 3'd1);
    post(1, 1'b0, 1'b0, 3'd2);
    nc(20);
    check_eq("t3_novf1",   n_ovf1 - bo1, 1);
    check_eq("t3_ovf1_cyc", ovf1_cyc - t, 5);
    check_eq("t3_novf0",   n_ovf0 - bo0, 0);
    check_eq("t3_nstart",  n_start - bs, 2);
    check_eq("t3_s1_pos",  start_pos[bs+1], 2);
    check_eq("t3_s1_gid",  start_gid[bs+1], 1);
    check_eq("t3_ndone1",  n_done1 - bd1, 1);
    check_eq("t3_ndone0",  n_done0 - bd0, 1);

    // 4: alternating contention
    do_reset();
    bs = n_start;
    req1_valid = 1'b1; req1_item = 1'b0; req1_erase = 1'b0; req1_pos = 3'd1;
    post(0, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int w = 0; w < 40 && !found; w++) begin
        @(negedge CLOCK_50);
        if (done0 || done1) found = 1'b1;
      end
      check_eq("t4_done_seen", int'(found), 1);
      if (done0) post(0, 1'b1, 1'b0, 3'd0);
      else       post(1, 1'b0, 1'b0, 3'd1);
    end
    nc(25);
    check_eq("t4_g0", start_gid[bs],   0);
    check_eq("t4_g1", start_gid[bs+1], 1);
    check_eq("t4_g2", start_gid[bs+2], 0);
    check_eq("t4_g3", start_gid[bs+3], 1);
    nc(20);

    // 5: reset in the middle of WAIT
    do_reset();
    bs = n_start; bd0 = n_done0; bd1 = n_done1;
    post(0, 1'b1, 1'b0, 3'd3);
    nc(1);
    post(1, 1'b0, 1'b0, 3'd4);
    nc(1);
    reset_n = 1'b0;
    nc(1);
    check_eq("t5_busy",  int'(busy), 0);
    check_eq("t5_pos",   int'(drw_pos), 0);
    check_eq("t5_item",  int'(drw_item), 0);
    check_eq("t5_start", int'(drw_start), 0);
    reset_n = 1'b1;
    nc(25);
    check_eq("t5_nstart", n_start - bs, 1);
    check_eq("t5_ndone0", n_done0 - bd0, 0);
    check_eq("t5_ndone1", n_done1 - bd1, 0);

    // 6: new req0 on the grant cycle of its previous command
    bs = n_start; bd0 = n_done0; bo0 = n_ovf0;
    t = cyc;
    post(0, 1'b1, 1'b0, 3'd1);
    post(0, 1'b0, 1'b1, 3'd2);
    nc(20);
    check_eq("t6_novf0",   n_ovf0 - bo0, 0);
    check_eq("t6_ndone0",  n_done0 - bd0, 2);
    check_eq("t6_nstart",  n_start - bs, 2);
    check_eq("t6_s0_pos",  start_pos[bs], 1);
    check_eq("t6_s1_pos",  start_pos[bs+1], 2);
    check_eq("t6_s1_item", start_item[bs+1], 0);
    check_eq("t6_s1_ers",  start_ers[bs+1], 1);
    check_eq("t6_s1_cyc",  start_cyc[bs+1] - t, 10);
    check_eq("t6_d0_cyc",  done0_cyc[bd0] - t, 8);
    check_eq("t6_d1_cyc",  done0_cyc[bd0+1] - t, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
